// File: rtl/tlb_arb_pkg.sv
// Shared types and the round-robin pick helper for the N-channel TLB request arbiter.
// Pure declarations; no state.
package tlb_arb_pkg;

  // Channel IDs are sized for the largest supported channel count.
  // Every instance therefore shares one ID type.
  localparam int MAX_CH    = 16;
  localparam int VPN_W_DEF = 27;
  localparam int PPN_W_DEF = 44;

  typedef logic [$clog2(MAX_CH)-1:0] ch_id_t;
  typedef logic [VPN_W_DEF-1:0]      vpn_t;
  typedef logic [PPN_W_DEF-1:0]      ppn_t;

  // Returns the first valid channel at or after ptr, wrapping at num_ch.
  // When no channel is valid it returns ptr.
  function automatic ch_id_t rr_pick(input logic [MAX_CH-1:0] valid,
                                     input ch_id_t            ptr,
                                     input int                num_ch);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < num_ch) begin
        idx = int'(ptr) + k;
        if (idx >= num_ch) idx = idx - num_ch;
        if (!found && valid[idx]) begin
          rr_pick = ch_id_t'(idx);
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/tlb_req_arbiter_n_id_fifo.sv
// In-order FIFO of granted channel IDs; head is visible combinationally, push/pop take effect on the edge.
// No internal backpressure: the caller must not push when full or pop when empty.
module id_fifo
  import tlb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  ch_id_t                   push_id,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output ch_id_t                   head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  ch_id_t        mem_q [DEPTH];
  ch_id_t        mem_d [DEPTH];

  // Pointers carry one extra wrap bit; the low bits select the slot.
  function automatic logic [AW-1:0] slot(input logic [PW-1:0] p);
    slot = (DEPTH == 1) ? '0 : AW'(p);
  endfunction

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (slot(wr_q) == slot(rd_q));
  assign count = wr_q - rd_q;
  assign head  = mem_q[slot(rd_q)];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[slot(wr_q)] = push_id;
      wr_d              = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/tlb_req_arbiter_n.sv
// Round-robin arbiter from NUM_CH channels onto one TLB port, with in-order response steering.
// Zero-cycle grant and response paths; requests stall while tlb_req_ready is low or MAX_OUT lookups are in flight.
module tlb_req_arbiter_n
  import tlb_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44,
  parameter int MAX_OUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             ch_req_valid,
  output logic [NUM_CH-1:0]             ch_req_ready,
  input  logic [NUM_CH*VPN_W-1:0]       ch_req_vpn,
  output logic [NUM_CH-1:0]             ch_resp_valid,
  output logic [PPN_W-1:0]              ch_resp_ppn,
  output logic                          ch_resp_fault,
  output logic                          tlb_req_valid,
  input  logic                          tlb_req_ready,
  output logic [VPN_W-1:0]              tlb_req_vpn,
  input  logic                          tlb_resp_valid,
  input  logic [PPN_W-1:0]              tlb_resp_ppn,
  input  logic                          tlb_resp_fault,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
  output logic                          err_orphan_resp
);

  ch_id_t            rr_q, rr_d, grant, head;
  logic [MAX_CH-1:0] valid_ext;
  logic              any_vld, full, empty, fire, pop;
  logic              err_q, err_d;

  always_comb begin
    valid_ext = '0;
    for (int i = 0; i < NUM_CH; i++) valid_ext[i] = ch_req_valid[i];
  end

  assign any_vld       = |ch_req_valid;
  assign grant         = rr_pick(valid_ext, rr_q, NUM_CH);
  assign tlb_req_valid = any_vld && !full;
  assign fire          = tlb_req_valid && tlb_req_ready;
  assign pop           = tlb_resp_valid && !empty;

  always_comb begin
    tlb_req_vpn   = '0;
    ch_req_ready  = '0;
    ch_resp_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == ch_id_t'(i)) begin
        tlb_req_vpn     = ch_req_vpn[i*VPN_W +: VPN_W];
        ch_req_ready[i] = tlb_req_ready && !full && ch_req_valid[i];
      end
      ch_resp_valid[i] = pop && (head == ch_id_t'(i));
    end
  end

  assign ch_resp_ppn   = pop ? tlb_resp_ppn : '0;
  assign ch_resp_fault = pop && tlb_resp_fault;

  // A response seen while nothing is registered as in flight is an orphan,
  // including one that coincides with the push of a brand-new request.
  assign err_d = err_q || (tlb_resp_valid && empty);

  always_comb begin
    rr_d = rr_q;
    if (fire) rr_d = (grant == ch_id_t'(NUM_CH - 1)) ? '0 : grant + ch_id_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

  assign err_orphan_resp = err_q;

  id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fire),
    .push_id (grant),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .count   (outstanding),
    .head    (head)
  );

endmodule

// File: tb/tb_tlb_req_arbiter_n.sv
// Bench for tlb_req_arbiter_n: directed vector table, hand sequences and a queue-based reference model.
module tb_tlb_req_arbiter_n;

  localparam int NCH = 2;
  localparam int VW  = 27;
  localparam int PW  = 44;
  localparam int MO  = 4;

  logic            clk, rst_n;
  logic [NCH-1:0]  ch_req_valid, ch_req_ready, ch_resp_valid;
  logic [NCH*VW-1:0] ch_req_vpn;
  logic [PW-1:0]   ch_resp_ppn, tlb_resp_ppn;
  logic            ch_resp_fault, tlb_req_valid, tlb_req_ready;
  logic [VW-1:0]   tlb_req_vpn;
  logic            tlb_resp_valid, tlb_resp_fault, err_orphan_resp;
  logic [2:0]      outstanding;

  // Second instance with three channels for the wrap-around fairness check.
  logic [2:0]      v3, rdy3, rv3;
  logic [3*VW-1:0] vpn3;
  logic [PW-1:0]   ppn3;
  logic            fault3, tv3;
  logic [VW-1:0]   tvpn3;
  logic [2:0]      out3;
  logic            err3;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   mq[$];
  int   rr_m;
  logic err_m;

  tlb_req_arbiter_n #(.NUM_CH(NCH), .VPN_W(VW), .PPN_W(PW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_vpn(ch_req_vpn),
    .ch_resp_valid(ch_resp_valid), .ch_resp_ppn(ch_resp_ppn), .ch_resp_fault(ch_resp_fault),
    .tlb_req_valid(tlb_req_valid), .tlb_req_ready(tlb_req_ready), .tlb_req_vpn(tlb_req_vpn),
    .tlb_resp_valid(tlb_resp_valid), .tlb_resp_ppn(tlb_resp_ppn), .tlb_resp_fault(tlb_resp_fault),
    .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
  );

  tlb_req_arbiter_n #(.NUM_CH(3), .VPN_W(VW), .PPN_W(PW), .MAX_OUT(MO)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .ch_req_valid(v3), .ch_req_ready(rdy3), .ch_req_vpn(vpn3),
    .ch_resp_valid(rv3), .ch_resp_ppn(ppn3), .ch_resp_fault(fault3),
    .tlb_req_valid(tv3), .tlb_req_ready(1'b1), .tlb_req_vpn(tvpn3),
    .tlb_resp_valid(1'b0), .tlb_resp_ppn('0), .tlb_resp_fault(1'b0),
    .outstanding(out3), .err_orphan_resp(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    ch_req_valid   = '0;
    ch_req_vpn     = '0;
    tlb_req_ready  = 1'b0;
    tlb_resp_valid = 1'b0;
    tlb_resp_ppn   = '0;
    tlb_resp_fault = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    rr_m  = 0;
    err_m = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ch_req_ready"},    64'(ch_req_ready), 64'(0));
    chk({tag, " ch_resp_valid"},   64'(ch_resp_valid), 64'(0));
    chk({tag, " ch_resp_ppn"},     64'(ch_resp_ppn), 64'(0));
    chk({tag, " ch_resp_fault"},   64'(ch_resp_fault), 64'(0));
    chk({tag, " tlb_req_valid"},   64'(tlb_req_valid), 64'(0));
    chk({tag, " tlb_req_vpn"},     64'(tlb_req_vpn), 64'(0));
    chk({tag, " outstanding"},     64'(outstanding), 64'(0));
    chk({tag, " err_orphan_resp"}, 64'(err_orphan_resp), 64'(0));
  endtask

  // Called at posedge+1; leaves at the following posedge+1 with the model reset.
  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    #2;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // One model-checked cycle with the inputs currently driven; acc reports the accepted channel mask.
  task automatic mcycle(input string tag, output logic [1:0] acc);
    int         n, g;
    logic       anyv, e_tv;
    logic [1:0] e_rdy, e_rv;
    n    = mq.size();
    anyv = |ch_req_valid;
    g    = 0;
    for (int k = NCH - 1; k >= 0; k--)
      if (ch_req_valid[(rr_m + k) % NCH]) g = (rr_m + k) % NCH;
    e_tv  = anyv && (n < MO);
    e_rdy = (e_tv && tlb_req_ready) ? 2'(1 << g) : 2'b00;
    e_rv  = (tlb_resp_valid && n > 0) ? 2'(1 << mq[0]) : 2'b00;
    acc   = e_rdy;
    @(negedge clk);
    chk({tag, " tlb_req_valid"},   64'(tlb_req_valid), 64'(e_tv));
    if (e_tv) chk({tag, " tlb_req_vpn"}, 64'(tlb_req_vpn), 64'(ch_req_vpn[g*VW +: VW]));
    chk({tag, " ch_req_ready"},    64'(ch_req_ready), 64'(e_rdy));
    chk({tag, " ch_resp_valid"},   64'(ch_resp_valid), 64'(e_rv));
    if (e_rv != 2'b00) begin
      chk({tag, " ch_resp_ppn"},   64'(ch_resp_ppn), 64'(tlb_resp_ppn));
      chk({tag, " ch_resp_fault"}, 64'(ch_resp_fault), 64'(tlb_resp_fault));
    end
    chk({tag, " outstanding"},     64'(outstanding), 64'(n));
    chk({tag, " err_orphan_resp"}, 64'(err_orphan_resp), 64'(err_m));
    @(posedge clk);
    if (tlb_resp_valid && n == 0) err_m = 1'b1;
    if (tlb_resp_valid && n > 0) void'(mq.pop_front());
    if (e_tv && tlb_req_ready) begin
      mq.push_back(g);
      rr_m = (g + 1) % NCH;
    end
    #1;
  endtask

  typedef struct {
    logic [1:0]    vld;
    logic [VW-1:0] vpn0;
    logic [VW-1:0] vpn1;
    logic          rdy;
    logic          resp;
    logic [PW-1:0] ppn;
    logic          fault;
    logic          e_tv;
    logic [VW-1:0] e_vpn;
    logic [1:0]    e_rdy;
    logic [1:0]    e_rv;
    logic [2:0]    e_out;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  initial begin
    logic [1:0]    acc;
    logic [1:0]    pend;
    logic [VW-1:0] pv [NCH];
    logic [2:0]    fair3 [4];

    rst_n = 1'b0;
    set_idle();
    v3    = '0;
    vpn3  = '0;
    model_clear();

    //        vld    vpn0      vpn1      rdy   resp  ppn       flt   e_tv  e_vpn     e_rdy  e_rv   e_out
    vt[0]  = '{2'b10, 27'h0,    27'h1234, 1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'h1234, 2'b10, 2'b00, 3'd0};
    vt[1]  = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b0, 44'h0,    1'b0, 1'b0, 27'h0,    2'b00, 2'b00, 3'd1};
    vt[2]  = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b1, 44'hABC,  1'b0, 1'b0, 27'h0,    2'b00, 2'b10, 3'd1};
    vt[3]  = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b0, 44'h0,    1'b0, 1'b0, 27'h0,    2'b00, 2'b00, 3'd0};
    vt[4]  = '{2'b01, 27'hAAA,  27'h0,    1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'hAAA,  2'b01, 2'b00, 3'd0};
    vt[5]  = '{2'b10, 27'h0,    27'hBBB,  1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'hBBB,  2'b10, 2'b00, 3'd1};
    vt[6]  = '{2'b01, 27'hCCC,  27'h0,    1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'hCCC,  2'b01, 2'b00, 3'd2};
    vt[7]  = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b1, 44'h111,  1'b0, 1'b0, 27'h0,    2'b00, 2'b01, 3'd3};
    vt[8]  = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b1, 44'h222,  1'b1, 1'b0, 27'h0,    2'b00, 2'b10, 3'd2};
    vt[9]  = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b1, 44'h333,  1'b0, 1'b0, 27'h0,    2'b00, 2'b01, 3'd1};
    vt[10] = '{2'b00, 27'h0,    27'h0,    1'b1, 1'b0, 44'h0,    1'b0, 1'b0, 27'h0,    2'b00, 2'b00, 3'd0};
    vt[11] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'h11,   2'b10, 2'b00, 3'd0};
    vt[12] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'h10,   2'b01, 2'b00, 3'd1};
    vt[13] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'h11,   2'b10, 2'b00, 3'd2};
    vt[14] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'h10,   2'b01, 2'b00, 3'd3};
    vt[15] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b0, 44'h0,    1'b0, 1'b0, 27'h0,    2'b00, 2'b00, 3'd4};
    vt[16] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b1, 44'h444,  1'b0, 1'b0, 27'h0,    2'b00, 2'b10, 3'd4};
    vt[17] = '{2'b11, 27'h10,   27'h11,   1'b1, 1'b0, 44'h0,    1'b0, 1'b1, 27'h11,   2'b10, 2'b00, 3'd3};

    fair3[0] = 3'b001;
    fair3[1] = 3'b010;
    fair3[2] = 3'b100;
    fair3[3] = 3'b001;

    @(posedge clk);
    #1;
    do_reset();

    // Directed vector table: single request, in-order steering with fault, fairness, full.
    for (int i = 0; i < NV; i++) begin
      ch_req_valid   = vt[i].vld;
      ch_req_vpn     = {vt[i].vpn1, vt[i].vpn0};
      tlb_req_ready  = vt[i].rdy;
      tlb_resp_valid = vt[i].resp;
      tlb_resp_ppn   = vt[i].ppn;
      tlb_resp_fault = vt[i].fault;
      @(negedge clk);
      chk($sformatf("vec%0d tlb_req_valid", i), 64'(tlb_req_valid), 64'(vt[i].e_tv));
      if (vt[i].e_tv) chk($sformatf("vec%0d tlb_req_vpn", i), 64'(tlb_req_vpn), 64'(vt[i].e_vpn));
      chk($sformatf("vec%0d ch_req_ready", i), 64'(ch_req_ready), 64'(vt[i].e_rdy));
      chk($sformatf("vec%0d ch_resp_valid", i), 64'(ch_resp_valid), 64'(vt[i].e_rv));
      if (vt[i].e_rv != 2'b00) begin
        chk($sformatf("vec%0d ch_resp_ppn", i), 64'(ch_resp_ppn), 64'(vt[i].ppn));
        chk($sformatf("vec%0d ch_resp_fault", i), 64'(ch_resp_fault), 64'(vt[i].fault));
      end
      chk($sformatf("vec%0d outstanding", i), 64'(outstanding), 64'(vt[i].e_out));
      @(posedge clk);
      #1;
    end
    do_reset();

    // Three-channel fairness: grants 0,1,2,0.
    v3   = 3'b111;
    vpn3 = {27'h333, 27'h222, 27'h111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("fair3 step%0d ready", i), 64'(rdy3), 64'(fair3[i]));
      @(posedge clk);
      #1;
    end
    v3 = '0;
    do_reset();

    // Back-pressure: five stalled cycles, then exactly one push.
    ch_req_valid = 2'b01;
    ch_req_vpn   = {27'h66, 27'h55};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ch_req_valid = 2'b11;
      mcycle($sformatf("stall%0d", i), acc);
      chk($sformatf("stall%0d no accept", i), 64'(ch_req_ready), 64'(0));
      chk($sformatf("stall%0d grant ch0", i), 64'(tlb_req_vpn), 64'(27'h55));
    end
    ch_req_valid  = 2'b01;
    tlb_req_ready = 1'b1;
    mcycle("stall release", acc);
    chk("stall release accept", 64'(acc), 64'(2'b01));
    ch_req_valid = 2'b11;
    mcycle("after stall rr", acc);
    chk("after stall grant ch1", 64'(acc), 64'(2'b10));
    set_idle();
    mcycle("after stall idle", acc);
    chk("after stall outstanding", 64'(outstanding), 64'(2));

    // Orphan on an empty FIFO, then reset mid-traffic.
    do_reset();
    tlb_resp_valid = 1'b1;
    tlb_resp_ppn   = 44'h777;
    mcycle("orphan", acc);
    tlb_resp_valid = 1'b0;
    mcycle("orphan sticky", acc);
    chk("orphan err set", 64'(err_orphan_resp), 64'(1));
    ch_req_valid  = 2'b11;
    tlb_req_ready = 1'b1;
    mcycle("pre-reset req0", acc);
    mcycle("pre-reset req1", acc);
    set_idle();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid reset");
    #3;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    tlb_resp_valid = 1'b1;
    mcycle("stale resp", acc);
    tlb_resp_valid = 1'b0;
    mcycle("stale resp err", acc);
    chk("stale resp err set", 64'(err_orphan_resp), 64'(1));

    // Randomised traffic against the queue model; channels hold requests until accepted.
    do_reset();
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          pv[i]   = VW'($urandom);
        end
      end
      ch_req_valid   = pend;
      ch_req_vpn     = {pv[1], pv[0]};
      tlb_req_ready  = ($urandom % 4 != 0);
      tlb_resp_valid = (mq.size() > 0) ? 1'($urandom % 2) : ($urandom % 25 == 0);
      tlb_resp_ppn   = PW'({$urandom, $urandom});
      tlb_resp_fault = 1'($urandom % 2);
      mcycle($sformatf("rand%0d", c), acc);
      pend = pend & ~acc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
